// File: rtl/trigger_pkg.sv
// Shared types and defaults for the trigger path (comparators and sequencer).
package trigger_pkg;

  localparam int DEF_NCMP = 4;
  localparam int DEF_NST  = 4;
  localparam int DEF_CNW  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    DELAY = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// Combinational hit evaluation for the currently selected sequence stage.
module trigger_stage_match
  import trigger_pkg::*;
#(
  parameter int NCMP = DEF_NCMP,
  parameter int NST  = DEF_NST,
  parameter int SW   = (clog2(DEF_NST) > 0) ? clog2(DEF_NST) : 1
) (
  input  logic [NST*NCMP-1:0] msk,
  input  logic [NST-1:0]      mod,
  input  logic [SW-1:0]       stg,
  input  logic [NCMP-1:0]     evt,
  output logic                hit
);

  logic [NCMP-1:0] sel_msk;
  logic            sel_mod;

  // OR mode: any selected comparator; AND mode: all selected comparators.
  always_comb begin
    sel_msk = msk[stg*NCMP +: NCMP];
    sel_mod = mod[stg];
    hit     = sel_mod ? (&(evt | ~sel_msk)) : (|(evt & sel_msk));
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: counts qualified comparator hits per stage,
// applies an optional post-trigger transfer delay, then pulses sts_trg once.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int NCMP = DEF_NCMP,
  parameter int NST  = DEF_NST,
  parameter int CNW  = DEF_CNW,
  localparam int SW  = (clog2(NST) > 0) ? clog2(NST) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_arm,
  input  logic                cfg_disarm,
  input  logic [NST*NCMP-1:0] cfg_msk,
  input  logic [NST-1:0]      cfg_mod,
  input  logic [NST*CNW-1:0]  cfg_cnt,
  input  logic [SW-1:0]       cfg_lst,
  input  logic [CNW-1:0]      cfg_dly,
  input  logic                sti_transfer,
  input  logic [NCMP-1:0]     evt,
  output logic                sts_armed,
  output logic [SW-1:0]       sts_stg,
  output logic                sts_trg,
  output logic                sts_done
);

  state_t        state;
  logic          vld;
  logic [SW-1:0] stg;
  logic [SW-1:0] lst;
  logic [CNW-1:0] hcnt;
  logic [CNW-1:0] dcnt;
  logic [CNW-1:0] req;
  logic [CNW:0]   hnext;
  logic          trg;
  logic          hit;

  trigger_stage_match #(
    .NCMP (NCMP),
    .NST  (NST),
    .SW   (SW)
  ) u_match (
    .msk (cfg_msk),
    .mod (cfg_mod),
    .stg (stg),
    .evt (evt),
    .hit (hit)
  );

  always_comb begin
    lst = (int'(cfg_lst) > NST - 1) ? SW'(NST - 1) : cfg_lst;
    req = cfg_cnt[stg*CNW +: CNW];
    if (req == '0) req = CNW'(1);
    hnext = {1'b0, hcnt} + (CNW+1)'(1);
  end

  // Comparators update evt on the transfer edge, so evt is valid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= 1'b0;
      state <= IDLE;
      stg   <= '0;
      hcnt  <= '0;
      dcnt  <= '0;
      trg   <= 1'b0;
    end else begin
      vld <= sti_transfer;
      trg <= 1'b0;
      if (cfg_disarm) begin
        state <= IDLE;
        stg   <= '0;
        hcnt  <= '0;
        dcnt  <= '0;
      end else if (cfg_arm) begin
        state <= STAGE;
        stg   <= '0;
        hcnt  <= '0;
        dcnt  <= '0;
      end else begin
        case (state)
          STAGE: begin
            if (vld && hit) begin
              if (hnext >= {1'b0, req}) begin
                // The completing hit is consumed here; the next stage starts from zero.
                if (stg == lst) begin
                  hcnt <= '0;
                  if (cfg_dly != '0) begin
                    state <= DELAY;
                    dcnt  <= cfg_dly;
                  end else begin
                    state <= DONE;
                    trg   <= 1'b1;
                  end
                end else begin
                  stg  <= stg + SW'(1);
                  hcnt <= '0;
                end
              end else begin
                hcnt <= (&hcnt) ? hcnt : hnext[CNW-1:0];
              end
            end
          end
          DELAY: begin
            if (vld) begin
              if (dcnt == CNW'(1)) begin
                state <= DONE;
                dcnt  <= '0;
                trg   <= 1'b1;
              end else begin
                dcnt <= dcnt - CNW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sts_armed = (state == STAGE) || (state == DELAY);
  assign sts_done  = (state == DONE);
  assign sts_stg   = stg;
  assign sts_trg   = trg;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench: stimulus enqueues samples/controls, a negedge monitor runs
// a sample-level reference model and checks status and trigger timing.
module tb_trigger_sequencer;

  localparam int NCMP = 4;
  localparam int NST  = 4;
  localparam int CNW  = 16;

  logic        clk;
  logic        rst;
  logic        cfg_arm;
  logic        cfg_disarm;
  logic [15:0] cfg_msk;
  logic [3:0]  cfg_mod;
  logic [63:0] cfg_cnt;
  logic [1:0]  cfg_lst;
  logic [15:0] cfg_dly;
  logic        sti_transfer;
  logic [3:0]  evt;
  logic        sts_armed;
  logic [1:0]  sts_stg;
  logic        sts_trg;
  logic        sts_done;

  trigger_sequencer #(
    .NCMP (NCMP),
    .NST  (NST),
    .CNW  (CNW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_arm      (cfg_arm),
    .cfg_disarm   (cfg_disarm),
    .cfg_msk      (cfg_msk),
    .cfg_mod      (cfg_mod),
    .cfg_cnt      (cfg_cnt),
    .cfg_lst      (cfg_lst),
    .cfg_dly      (cfg_dly),
    .sti_transfer (sti_transfer),
    .evt          (evt),
    .sts_armed    (sts_armed),
    .sts_stg      (sts_stg),
    .sts_trg      (sts_trg),
    .sts_done     (sts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int at; logic [3:0] e; } smp_t;
  typedef struct { int at; int kind; } ctl_t;  // kind: 1 arm, 2 disarm, 3 both
  smp_t smp_q[$];
  ctl_t ctl_q[$];
  int   exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 seeking hits, 2 counting delay, 3 complete.
  int m_phase = 0;
  int m_stage = 0;
  int m_hits  = 0;
  int m_left  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_stage = 0; m_hits = 0; m_left = 0;
    smp_q.delete(); ctl_q.delete(); exp_q.delete();
  endtask

  task automatic model_sample(input logic [3:0] e, input int c);
    logic [15:0] mv;
    logic [63:0] cv;
    int m, need, last;
    bit hit;
    last = (int'(cfg_lst) > NST - 1) ? NST - 1 : int'(cfg_lst);
    if (m_phase == 1) begin
      mv = cfg_msk >> (m_stage * 4);
      cv = cfg_cnt >> (m_stage * 16);
      m = int'(mv[3:0]);
      need = int'(cv[15:0]);
      if (need == 0) need = 1;
      if (cfg_mod[m_stage]) hit = ((int'(e) & m) == m);
      else                  hit = ((int'(e) & m) != 0);
      if (hit) begin
        m_hits++;
        if (m_hits >= need) begin
          m_hits = 0;
          if (m_stage == last) begin
            if (cfg_dly != 0) begin m_phase = 2; m_left = int'(cfg_dly); end
            else begin m_phase = 3; exp_q.push_back(c); end
          end else begin
            m_stage++;
          end
        end
      end
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) begin m_phase = 3; exp_q.push_back(c); end
    end
  endtask

  always @(negedge clk) begin
    bit ctl_now;
    if (!rst) begin
      ctl_now = 1'b0;
      while (ctl_q.size() > 0 && ctl_q[0].at <= cyc) begin
        if (ctl_q[0].at == cyc) begin
          ctl_now = 1'b1;
          m_stage = 0; m_hits = 0; m_left = 0;
          m_phase = (ctl_q[0].kind == 1) ? 1 : 0;
        end
        void'(ctl_q.pop_front());
      end
      while (smp_q.size() > 0 && smp_q[0].at <= cyc) begin
        if (smp_q[0].at == cyc && !ctl_now) model_sample(smp_q[0].e, cyc);
        void'(smp_q.pop_front());
      end
      check("armed", int'(sts_armed), int'(m_phase == 1 || m_phase == 2));
      check("stg",   int'(sts_stg),   m_stage);
      check("done",  int'(sts_done),  int'(m_phase == 3));
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("trg_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (sts_trg) begin
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          check("trg_time", cyc, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          check("trg_unexpected", 1, 0);
        end
      end
    end
  end

  task automatic xfer(input logic [3:0] e, input int gap);
    @(negedge clk);
    sti_transfer = 1'b1;
    smp_q.push_back('{at: cyc + 2, e: e});
    @(posedge clk);
    #1;
    evt = e;
    sti_transfer = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic ctl(input int kind);
    @(negedge clk);
    cfg_arm    = (kind == 1 || kind == 3);
    cfg_disarm = (kind == 2 || kind == 3);
    ctl_q.push_back('{at: cyc + 1, kind: kind});
    @(posedge clk);
    #1;
    cfg_arm = 1'b0;
    cfg_disarm = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic [15:0] msk, input logic [3:0] mod,
                       input logic [63:0] cnt, input logic [1:0] lst,
                       input logic [15:0] dly);
    cfg_msk = msk; cfg_mod = mod; cfg_cnt = cnt; cfg_lst = lst; cfg_dly = dly;
  endtask

  initial begin
    rst = 1'b1; cfg_arm = 0; cfg_disarm = 0; sti_transfer = 0; evt = '0;
    setup(16'h0001, 4'h0, 64'h1, 2'd0, 16'd0);
    repeat (3) @(posedge clk);
    #2;
    check("rst_armed", int'(sts_armed), 0);
    check("rst_stg",   int'(sts_stg),   0);
    check("rst_trg",   int'(sts_trg),   0);
    check("rst_done",  int'(sts_done),  0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Single stage, immediate trigger
    ctl(1);
    xfer(4'b0001, 4);
    idle(2);

    // Two stages with non-consecutive hits; evt1 coincident with completing hit
    setup(16'h0021, 4'h0, {16'd0, 16'd0, 16'd1, 16'd3}, 2'd1, 16'd0);
    ctl(1);
    xfer(4'b0001, 0); xfer(4'b0000, 0); xfer(4'b0000, 0);
    xfer(4'b0001, 1); xfer(4'b0000, 0); xfer(4'b0000, 0);
    xfer(4'b0011, 2);
    xfer(4'b0010, 3);
    ctl(2);

    // AND mode
    setup(16'h0003, 4'h1, 64'h1, 2'd0, 16'd0);
    ctl(1);
    for (int i = 0; i < 5; i++) xfer(4'b0001, 1);
    xfer(4'b0111, 3);
    // All-zero mask in OR mode never hits
    setup(16'h0000, 4'h0, 64'h1, 2'd0, 16'd0);
    ctl(1);
    for (int i = 0; i < 6; i++) xfer(4'($urandom), 0);
    idle(2);
    ctl(2);

    // Post-trigger delay counts transfers, not clocks
    setup(16'h0001, 4'h0, 64'h1, 2'd0, 16'd5);
    ctl(1);
    xfer(4'b0001, 1);
    for (int i = 0; i < 5; i++) xfer(4'($urandom), $urandom_range(0, 3));
    idle(3);

    // Arm and disarm together
    ctl(1);
    ctl(3);
    idle(2);
    // Arm during DELAY restarts without a trigger
    ctl(1);
    xfer(4'b0001, 0);
    xfer(4'b0000, 1);
    ctl(1);
    idle(2);
    ctl(2);
    // Zero count behaves as one
    setup(16'h0001, 4'h0, 64'h0, 2'd0, 16'd0);
    ctl(1);
    xfer(4'b0001, 3);

    // Async reset mid-DELAY
    setup(16'h0001, 4'h0, 64'h1, 2'd0, 16'd5);
    ctl(1);
    xfer(4'b0001, 0);
    xfer(4'b0000, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("arst_armed", int'(sts_armed), 0);
    check("arst_stg",   int'(sts_stg),   0);
    check("arst_trg",   int'(sts_trg),   0);
    check("arst_done",  int'(sts_done),  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) xfer(4'b0001, 0);
    idle(4);

    // Randomized configurations and streams
    for (int it = 0; it < 25; it++) begin
      ctl(2);
      for (int s = 0; s < NST; s++) begin
        cfg_msk[s*4 +: 4]   = 4'($urandom);
        cfg_cnt[s*16 +: 16] = 16'($urandom_range(0, 3));
      end
      cfg_mod = 4'($urandom);
      cfg_lst = 2'($urandom);
      cfg_dly = 16'($urandom_range(0, 4));
      ctl(1);
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 24) == 0) ctl(1);
        else xfer(4'($urandom), $urandom_range(0, 2));
      end
      idle(3);
    end
    ctl(2);
    idle(4);

    while (exp_q.size() > 0) begin
      check("trg_missing_end", 0, 1);
      void'(exp_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
